// File: rtl/dac_spi_pkg.sv
// Shared state encoding, register map constants and reset helper for the
// DAC-side SPI responder.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        WR,
        RD,
        HOLD
    } state_e;

    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] REG_ID = 5'h1F;
    localparam logic [ADDR_W-1:0] REG_CTRL = 5'h00;
    localparam int SDIODIR = 7;
    localparam int SOFTRST = 5;

    function automatic logic [7:0] regResetVal(input logic [ADDR_W-1:0] addr,
                                               input logic [7:0] chipId);
        return (addr == REG_ID) ? chipId : 8'h00;
    endfunction

endpackage

// File: rtl/dac_spi_in_sync.sv
// Multi-bit synchroniser for asynchronous SPI pins with rise/fall detection
// on the synchronised values.
module spi_in_sync #(
    parameter int WIDTH = 1,
    parameter int STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= RESET_VAL;
            end
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/dac_spi_responder.sv
// Clock-oversampled SPI responder modelling the DAC end of the config port:
// 32 x 8 register file, DAC-style instruction decode, write reporting.
module dac_spi_responder
    import dac_spi_pkg::*;
#(
    parameter logic [7:0] CHIP_ID = 8'h0A,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              csb,
    input  logic              sdio_in,
    output logic              sdio_out,
    output logic              sdio_oe,
    output logic              sdo,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              abort,
    output logic              busy
);

    logic [2:0] pinSync, pinRise, pinFall;
    logic       sclkRise, sclkFall, csbSync, csbRise, sdioSync;
    logic       unusedEdges;

    // csb idles high, so its synchroniser resets high to avoid a phantom select
    spi_in_sync #(
        .WIDTH    (3),
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(3'b010)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_i   ({sdio_in, csb, sclk}),
        .q_o   (pinSync),
        .rise_o(pinRise),
        .fall_o(pinFall)
    );

    assign sclkRise    = pinRise[0];
    assign sclkFall    = pinFall[0];
    assign csbSync     = pinSync[1];
    assign csbRise     = pinRise[1];
    assign sdioSync    = pinSync[2];
    assign unusedEdges = ^{pinSync[0], pinFall[2:1], pinRise[2]};

    state_e            state_q, state_d;
    logic [2:0]        bitCnt_q, bitCnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        bytesLeft_q, bytesLeft_d;
    logic [7:0]        outShift_q, outShift_d;
    logic              wrStb_q, wrStb_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [7:0]        wrData_q, wrData_d;
    logic              abort_q, abort_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        inByte;
    logic              regWe, softRst, sdioDir;

    assign inByte = {shift_q[6:0], sdioSync};

    // csb release is checked first so a coincident sclk edge is dropped
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        bytesLeft_d = bytesLeft_q;
        outShift_d  = outShift_q;
        wrStb_d     = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        abort_d     = 1'b0;
        regWe       = 1'b0;
        softRst     = 1'b0;

        if (csbRise) begin
            softRst = regs_q[REG_CTRL][SOFTRST];
            state_d = IDLE;
            case (state_q)
                INSTR:   abort_d = (bitCnt_q != 3'd0);
                WR, RD:  abort_d = 1'b1;
                default: abort_d = 1'b0;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (!csbSync) begin
                        state_d    = INSTR;
                        bitCnt_d   = 3'd0;
                        outShift_d = 8'h00;
                    end
                end
                INSTR: begin
                    if (sclkRise) begin
                        shift_d  = inByte;
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            addr_d      = inByte[4:0];
                            bytesLeft_d = inByte[6:5];
                            state_d     = inByte[7] ? RD : WR;
                        end
                    end
                end
                WR: begin
                    if (sclkRise) begin
                        shift_d  = inByte;
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            if (addr_q != REG_ID) begin
                                regWe    = 1'b1;
                                wrStb_d  = 1'b1;
                                wrAddr_d = addr_q;
                                wrData_d = inByte;
                            end
                            addr_d = addr_q + ADDR_W'(1);
                            if (bytesLeft_q == 2'd0) begin
                                state_d = HOLD;
                            end else begin
                                bytesLeft_d = bytesLeft_q - 2'd1;
                            end
                        end
                    end
                end
                RD: begin
                    // Bit count tracks rising edges, so a fall at count 0 starts a new byte
                    if (sclkFall) begin
                        outShift_d = (bitCnt_q == 3'd0) ? regs_q[addr_q]
                                                        : {outShift_q[6:0], 1'b0};
                    end
                    if (sclkRise) begin
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            addr_d = addr_q + ADDR_W'(1);
                            if (bytesLeft_q == 2'd0) begin
                                state_d = HOLD;
                            end else begin
                                bytesLeft_d = bytesLeft_q - 2'd1;
                            end
                        end
                    end
                end
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            addr_q      <= '0;
            bytesLeft_q <= 2'd0;
            outShift_q  <= 8'h00;
            wrStb_q     <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= 8'h00;
            abort_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regResetVal(ADDR_W'(i), CHIP_ID);
            end
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            bytesLeft_q <= bytesLeft_d;
            outShift_q  <= outShift_d;
            wrStb_q     <= wrStb_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            abort_q     <= abort_d;
            if (softRst) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    regs_q[i] <= regResetVal(ADDR_W'(i), CHIP_ID);
                end
            end else if (regWe) begin
                regs_q[addr_q] <= inByte;
            end
        end
    end

    // Output enable also drops on the raw synchronised csb so release is immediate
    assign sdioDir  = regs_q[REG_CTRL][SDIODIR];
    assign sdio_out = ~sdioDir & outShift_q[7];
    assign sdo      = sdioDir & outShift_q[7];
    assign sdio_oe  = (state_q == RD) & ~sdioDir & ~csbSync;
    assign wr_stb   = wrStb_q;
    assign wr_addr  = wrAddr_q;
    assign wr_data  = wrData_q;
    assign abort    = abort_q;
    assign busy     = ~csbSync;

endmodule

// File: tb/tb_dac_spi_responder.sv
// Self-checking bench for dac_spi_responder: directed frame table, a reset
// mid-transfer sequence and random frames checked against a frame-level model.
module tb_dac_spi_responder;

    localparam logic [7:0] CHIP_ID = 8'h0A;

    logic       clk = 1'b0;
    logic       rst, sclk, csb, sdio_in;
    logic       sdio_out, sdio_oe, sdo, wr_stb, abort, busy;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    dac_spi_responder #(
        .CHIP_ID    (CHIP_ID),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .csb     (csb),
        .sdio_in (sdio_in),
        .sdio_out(sdio_out),
        .sdio_oe (sdio_oe),
        .sdo     (sdo),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .abort   (abort),
        .busy    (busy)
    );

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0]  txBuf [8];
    logic [7:0]  rx3Buf [8];
    logic [7:0]  rx4Buf [8];
    logic        oeSeenHigh, oeSeenLow, busyMid, busyEnd;
    logic [12:0] wrSeen [$];
    int          abortSeen = 0;

    // Frame-level reference model
    logic [7:0]  mReg [32];
    logic [12:0] expWr [$];
    logic [7:0]  expRd [4];
    int          expRdCnt, expAbort;
    logic        expWire4;

    always @(negedge clk) begin
        if (wr_stb) wrSeen.push_back({wr_addr, wr_data});
        if (abort) abortSeen++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic shiftBit(input logic b, output logic s3, output logic s4, output logic oe);
        sdio_in = b;
        repeat (8) @(negedge clk);
        s3 = sdio_out;
        s4 = sdo;
        oe = sdio_oe;
        sclk = 1'b1;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic applyStimulus(input int nBytes, input int partialBits);
        logic s3, s4, oe;
        wrSeen.delete();
        abortSeen  = 0;
        oeSeenHigh = 1'b0;
        oeSeenLow  = 1'b0;
        csb = 1'b0;
        repeat (8) @(negedge clk);
        busyMid = busy;
        for (int i = 0; i < nBytes; i++) begin
            for (int b = 7; b >= 0; b--) begin
                shiftBit(txBuf[i][b], s3, s4, oe);
                if (i > 0) begin
                    rx3Buf[i-1][b] = s3;
                    rx4Buf[i-1][b] = s4;
                    if (oe) oeSeenHigh = 1'b1;
                    else    oeSeenLow  = 1'b1;
                end
            end
        end
        for (int b = 0; b < partialBits; b++) begin
            shiftBit(txBuf[nBytes][7-b], s3, s4, oe);
        end
        repeat (8) @(negedge clk);
        csb = 1'b1;
        repeat (12) @(negedge clk);
        busyEnd = busy;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mReg[i] = 8'h00;
        mReg[31] = CHIP_ID;
    endtask

    task automatic modelFrame(input int nBytes, input int partialBits);
        int         n, dataBytes;
        logic [4:0] a;
        logic       isRead;
        expWr.delete();
        expRdCnt = 0;
        expWire4 = mReg[0][7];
        if (nBytes == 0) begin
            expAbort = (partialBits > 0) ? 1 : 0;
        end else begin
            isRead    = txBuf[0][7];
            n         = int'(txBuf[0][6:5]) + 1;
            a         = txBuf[0][4:0];
            dataBytes = nBytes - 1;
            for (int k = 0; k < n && k < dataBytes; k++) begin
                if (isRead) begin
                    expRd[k] = mReg[a];
                    expRdCnt++;
                end else if (a != 5'd31) begin
                    mReg[a] = txBuf[k+1];
                    expWr.push_back({a, txBuf[k+1]});
                end
                a = a + 5'd1;
            end
            expAbort = (dataBytes < n) ? 1 : 0;
        end
        if (mReg[0][5]) modelReset();
    endtask

    task automatic checkFrame(input string name);
        checkOutput({name, ".busyMid"}, busyMid, 1);
        checkOutput({name, ".busyEnd"}, busyEnd, 0);
        checkOutput({name, ".wrCnt"}, wrSeen.size(), expWr.size());
        for (int k = 0; k < expWr.size() && k < wrSeen.size(); k++) begin
            checkOutput({name, ".wr"}, wrSeen[k], expWr[k]);
        end
        checkOutput({name, ".abort"}, abortSeen, expAbort);
        if (expRdCnt > 0) begin
            for (int k = 0; k < expRdCnt; k++) begin
                if (expWire4) begin
                    checkOutput({name, ".sdo"}, rx4Buf[k], expRd[k]);
                end else begin
                    checkOutput({name, ".sdio"}, rx3Buf[k], expRd[k]);
                    checkOutput({name, ".sdoIdle"}, rx4Buf[k], 0);
                end
            end
            if (expWire4) checkOutput({name, ".oe4w"}, oeSeenHigh, 0);
            else          checkOutput({name, ".oe3w"}, oeSeenLow, 0);
        end
    endtask

    typedef struct {
        string       name;
        int          nBytes;
        int          partial;
        logic [31:0] tx;
        int          expWrCnt;
        int          expAbortCnt;
        int          expRdBytes;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
        logic        fourWire;
    } vec_t;

    vec_t vecs [$];

    task automatic addVec(input string name, input int nb, input int pb, input logic [31:0] tx,
                          input int w, input int ab, input int r, input logic [7:0] r0,
                          input logic [7:0] r1, input logic fw);
        vec_t v;
        v.name = name; v.nBytes = nb; v.partial = pb; v.tx = tx;
        v.expWrCnt = w; v.expAbortCnt = ab; v.expRdBytes = r;
        v.rd0 = r0; v.rd1 = r1; v.fourWire = fw;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] t;
        logic [7:0]  ins, rdBits;
        logic        s3, s4, oe;
        int          kind, n, nb, pb;
        logic [4:0]  addr;

        rst = 1'b1; csb = 1'b1; sclk = 1'b0; sdio_in = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst.sdio_out", sdio_out, 0);
        checkOutput("rst.sdio_oe", sdio_oe, 0);
        checkOutput("rst.sdo", sdo, 0);
        checkOutput("rst.wr_stb", wr_stb, 0);
        checkOutput("rst.wr_addr", wr_addr, 0);
        checkOutput("rst.wr_data", wr_data, 0);
        checkOutput("rst.abort", abort, 0);
        checkOutput("rst.busy", busy, 0);
        rst = 1'b0;
        modelReset();
        repeat (4) @(negedge clk);

        //     name           nB pb tx            wr ab rd r0     r1     4w
        addVec("wr03",         3, 0, 32'h23A55A00, 2, 0, 0, 8'h00, 8'h00, 0);
        addVec("rdId3w",       2, 0, 32'h9FC30000, 0, 0, 1, 8'h0A, 8'h00, 0);
        addVec("wrDir4w",      2, 0, 32'h00800000, 1, 0, 0, 8'h00, 8'h00, 0);
        addVec("rdWrap4w",     3, 0, 32'hBFC3C300, 0, 0, 2, 8'h0A, 8'h80, 1);
        addVec("wrDir3w",      2, 0, 32'h00000000, 1, 0, 0, 8'h00, 8'h00, 0);
        addVec("wrIdProt",     2, 0, 32'h1FFF0000, 0, 0, 0, 8'h00, 8'h00, 0);
        addVec("rdIdAgain",    2, 0, 32'h9FC30000, 0, 0, 1, 8'h0A, 8'h00, 0);
        addVec("abortMid",     1, 4, 32'h02F00000, 0, 1, 0, 8'h00, 8'h00, 0);
        addVec("rdReg2",       2, 0, 32'h82C30000, 0, 0, 1, 8'h00, 8'h00, 0);
        addVec("wr02",         2, 0, 32'h023C0000, 1, 0, 0, 8'h00, 8'h00, 0);
        addVec("rdReg2b",      2, 0, 32'h82C30000, 0, 0, 1, 8'h3C, 8'h00, 0);
        addVec("rdReg3to4",    3, 0, 32'hA3C3C300, 0, 0, 2, 8'hA5, 8'h5A, 0);
        addVec("softA",        2, 0, 32'h00200000, 1, 0, 0, 8'h00, 8'h00, 0);
        addVec("wr05",         2, 0, 32'h05770000, 1, 0, 0, 8'h00, 8'h00, 0);
        addVec("softB",        2, 0, 32'h00200000, 1, 0, 0, 8'h00, 8'h00, 0);
        addVec("rd05",         2, 0, 32'h85C30000, 0, 0, 1, 8'h00, 8'h00, 0);
        addVec("rd00",         2, 0, 32'h80C30000, 0, 0, 1, 8'h00, 8'h00, 0);
        addVec("abortBoundary", 2, 0, 32'h21110000, 1, 1, 0, 8'h00, 8'h00, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            t = vecs[r].tx;
            for (int i = 0; i < 8; i++) txBuf[i] = 8'h00;
            for (int i = 0; i < 4; i++) txBuf[i] = t[31-8*i -: 8];
            modelFrame(vecs[r].nBytes, vecs[r].partial);
            applyStimulus(vecs[r].nBytes, vecs[r].partial);
            checkOutput({vecs[r].name, ".tblWr"}, wrSeen.size(), vecs[r].expWrCnt);
            checkOutput({vecs[r].name, ".tblAbort"}, abortSeen, vecs[r].expAbortCnt);
            if (vecs[r].expRdBytes > 0)
                checkOutput({vecs[r].name, ".tblRd0"},
                            vecs[r].fourWire ? rx4Buf[0] : rx3Buf[0], vecs[r].rd0);
            if (vecs[r].expRdBytes > 1)
                checkOutput({vecs[r].name, ".tblRd1"},
                            vecs[r].fourWire ? rx4Buf[1] : rx3Buf[1], vecs[r].rd1);
            checkFrame(vecs[r].name);
        end

        // Reset asserted in the middle of a 3-wire read
        txBuf[0] = 8'h06; txBuf[1] = 8'h55;
        modelFrame(2, 0);
        applyStimulus(2, 0);
        checkFrame("wr06");
        ins = 8'h86;
        rdBits = 8'h00;
        csb = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 7; b >= 0; b--) shiftBit(ins[b], s3, s4, oe);
        for (int b = 7; b >= 5; b--) begin
            shiftBit(1'b0, s3, s4, oe);
            rdBits[b] = s3;
        end
        checkOutput("rstMid.bits", rdBits[7:5], 3'b010);
        checkOutput("rstMid.oeBefore", sdio_oe, 1);
        rst = 1'b1;
        #1;
        checkOutput("rstMid.oe", sdio_oe, 0);
        checkOutput("rstMid.busy", busy, 0);
        checkOutput("rstMid.sdio_out", sdio_out, 0);
        @(negedge clk);
        csb = 1'b1; sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        modelReset();
        repeat (4) @(negedge clk);
        txBuf[0] = 8'h86; txBuf[1] = 8'hC3;
        modelFrame(2, 0);
        applyStimulus(2, 0);
        checkOutput("rstMid.reg6", rx3Buf[0], 8'h00);
        checkFrame("rstMid.rd06");

        // Random frames against the model
        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 9);
            addr = 5'($urandom_range(0, 31));
            n    = $urandom_range(0, 3);
            pb   = 0;
            for (int i = 0; i < 8; i++) txBuf[i] = 8'($urandom);
            if (kind < 5) begin
                txBuf[0] = {1'b0, 2'(n), addr};
                nb = (kind == 4) ? n + 1 : n + 2;
            end else if (kind < 9) begin
                txBuf[0] = {1'b1, 2'(n), addr};
                nb = n + 2;
            end else begin
                txBuf[0] = {1'($urandom), 2'(n), addr};
                nb = 1 + $urandom_range(0, n);
                pb = $urandom_range(1, 7);
            end
            modelFrame(nb, pb);
            applyStimulus(nb, pb);
            checkFrame("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
